// File: rtl/nios2_oci_mem_arbiter_pkg.sv
// Shared types and JTAG data-register field offsets for the OCI debug-memory controller.
package nios2_oci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    J_ACC,
    J_CAP,
    C_ACC,
    C_CAP
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } jop_e;

  localparam int unsigned RD_BIT    = 35;
  localparam int unsigned ADDR_LSB  = 26;
  localparam int unsigned WDATA_LSB = 3;

endpackage

// File: rtl/nios2_oci_rr_arb2.sv
// Two-requester round-robin arbiter; last_q remembers which requester was granted last.
module nios2_oci_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    last_d = last_q;
    if (advance && (req != '0)) last_d = gnt[1];
  end

  // Reset to "req[0] granted last" so the first contended grant goes to req[1].
  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= 1'b0;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/nios2_oci_mem_arbiter.sv
// Sysclk-side debug-memory controller: one-deep JTAG command queue arbitrated
// round-robin against CPU Avalon accesses onto a single-port RAM.
module nios2_oci_mem_arbiter
  import nios2_oci_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W+1)'(ROM_WORDS);

  state_e            state_q, state_d;
  logic              jpend_q, jpend_d;
  jop_e              jop_q, jop_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic [31:0]       jdata_q, jdata_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              mon_ready_q, mon_ready_d;
  logic              mon_error_q, mon_error_d;

  logic [1:0] gnt;
  logic       cpu_req;
  logic       retire;
  logic       busy;
  logic       overrun;
  logic       unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign cpu_req    = avs_read | avs_write;

  nios2_oci_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({jpend_q, cpu_req}),
    .advance (state_q == IDLE),
    .gnt     (gnt)
  );

  always_comb begin
    state_d         = state_q;
    jpend_d         = jpend_q;
    jop_d           = jop_q;
    jaddr_d         = jaddr_q;
    jdata_d         = jdata_q;
    mon_dreg_d      = mon_dreg_q;
    mon_ready_d     = mon_ready_q;
    mon_error_d     = mon_error_q;
    ram_addr        = '0;
    ram_we          = 1'b0;
    ram_wdata       = '0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    retire          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt[1])      state_d = J_ACC;
        else if (gnt[0]) state_d = C_ACC;
      end
      J_ACC: begin
        ram_addr = jaddr_q;
        if (jop_q == OP_WR) begin
          ram_we    = 1'b1;
          ram_wdata = jdata_q;
          retire    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = J_CAP;
        end
      end
      J_CAP: begin
        mon_dreg_d = ram_rdata;
        retire     = 1'b1;
        state_d    = IDLE;
      end
      C_ACC: begin
        ram_addr = avs_address;
        if (avs_write) begin
          ram_we          = ({1'b0, avs_address} >= ROM_LIMIT);
          ram_wdata       = avs_writedata;
          avs_waitrequest = 1'b0;
          state_d         = IDLE;
        end else begin
          state_d = C_CAP;
        end
      end
      C_CAP: begin
        avs_readdata    = ram_rdata;
        avs_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // No access may complete while reset is being applied.
    if (!reset_n) begin
      ram_we          = 1'b0;
      avs_waitrequest = 1'b1;
    end

    if (retire) begin
      jpend_d     = 1'b0;
      jaddr_d     = jaddr_q + ADDR_W'(1);
      mon_ready_d = 1'b1;
    end

    // A new command overrides the retiring one's increment/ready in the same cycle.
    busy    = jpend_q && !retire;
    overrun = ((take_action_ocimem_a || take_action_ocimem_b) && busy) ||
              (take_action_ocimem_a && take_action_ocimem_b);
    if (!busy) begin
      if (take_action_ocimem_a) begin
        jaddr_d = jdo[ADDR_LSB +: ADDR_W];
        if (jdo[RD_BIT]) begin
          jpend_d     = 1'b1;
          jop_d       = OP_RD;
          mon_ready_d = 1'b0;
        end else begin
          mon_ready_d = 1'b1;
        end
      end else if (take_action_ocimem_b) begin
        jpend_d     = 1'b1;
        jop_d       = OP_WR;
        jdata_d     = jdo[WDATA_LSB +: 32];
        mon_ready_d = 1'b0;
      end
    end

    if (overrun)                      mon_error_d = 1'b1;
    else if (take_no_action_ocimem_a) mon_error_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      jpend_q     <= 1'b0;
      jop_q       <= OP_RD;
      jaddr_q     <= '0;
      jdata_q     <= '0;
      mon_dreg_q  <= '0;
      mon_ready_q <= 1'b0;
      mon_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      jpend_q     <= jpend_d;
      jop_q       <= jop_d;
      jaddr_q     <= jaddr_d;
      jdata_q     <= jdata_d;
      mon_dreg_q  <= mon_dreg_d;
      mon_ready_q <= mon_ready_d;
      mon_error_q <= mon_error_d;
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = mon_ready_q;
  assign monitor_error = mon_error_q;

endmodule

// File: tb/tb_nios2_oci_mem_arbiter.sv
// Self-checking bench: external RAM model plus a shadow-memory reference model.
module tb_nios2_oci_mem_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned ROM = 64;

  logic        clk = 1'b0;
  logic        reset_n, take_a, take_b, take_na;
  logic [37:0] jdo;
  logic [7:0]  avs_address, ram_addr;
  logic        avs_read, avs_write, avs_waitrequest, ram_we;
  logic [31:0] avs_writedata, avs_readdata, ram_wdata, ram_rdata, MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  nios2_oci_mem_arbiter #(.ADDR_W(AW), .ROM_WORDS(ROM)) dut (
    .clk(clk), .reset_n(reset_n),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_na), .jdo(jdo),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  // External single-port RAM with registered read, plus bench preload ports.
  logic [31:0] mem [256];
  logic        init_mem, bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data, seed;

  function automatic logic [31:0] init_val(input int unsigned i, input logic [31:0] s);
    return (i * 32'h9E3779B1) ^ s;
  endfunction

  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 256; i++) mem[i] <= init_val(i, seed);
    else if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic [31:0] ref_mem [256];
  logic [7:0]  m_jaddr;
  int          total = 0;
  int          bad = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; tick; tick; reset_n = 1'b1; m_jaddr = '0;
  endtask

  task automatic load_mem;
    seed = $urandom; init_mem = 1'b1; tick; init_mem = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i, seed);
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1; tick; bd_we = 1'b0; ref_mem[a] = d;
  endtask

  task automatic pulse_a(input logic [7:0] a, input logic rd);
    jdo = '0; jdo[26 +: 8] = a; jdo[35] = rd; take_a = 1'b1; tick; take_a = 1'b0;
    m_jaddr = a;
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = '0; jdo[3 +: 32] = d; take_b = 1'b1; tick; take_b = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!monitor_ready && n < 20) begin tick; n++; end
  endtask

  task automatic jtag_read(input logic [7:0] a, output logic [31:0] d, output int n);
    pulse_a(a, 1'b1); wait_ready(n); d = MonDReg; m_jaddr = m_jaddr + 8'd1;
  endtask

  task automatic jtag_write(input logic [31:0] d, output int n);
    pulse_b(d); wait_ready(n); ref_mem[m_jaddr] = d; m_jaddr = m_jaddr + 8'd1;
  endtask

  task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int n, output logic we_seen);
    avs_address = a; avs_writedata = d; avs_write = wr; avs_read = !wr;
    n = 0;
    do begin tick; n++; end while (avs_waitrequest && n < 20);
    rd = avs_readdata; we_seen = ram_we;
    tick; avs_read = 1'b0; avs_write = 1'b0;
    if (wr && a >= 8'(ROM)) ref_mem[a] = d;
  endtask

  // JTAG read strobed at cycle 0, CPU read raised from cycle 1: both visible to the same IDLE.
  task automatic contend(input logic [7:0] ja, input logic [7:0] ca,
                         output int jd, output int cd, output logic [31:0] jv, output logic [31:0] cv);
    pulse_a(ja, 1'b1);
    avs_address = ca; avs_read = 1'b1; jd = -1; cd = -1; jv = '0; cv = '0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (cd >= 0) avs_read = 1'b0;
      if (monitor_ready && jd < 0) begin jd = k; jv = MonDReg; end
      if (avs_read && !avs_waitrequest && cd < 0) begin cd = k; cv = avs_readdata; end
    end
    m_jaddr = ja + 8'd1;
  endtask

  task automatic check_mem(input string name);
    int diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    total++;
    if (diff != 0) begin bad++; $display("FAIL %s words_differing=%0d exp=0", name, diff); end
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
    total++; if (avs_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got=%b exp=1", avs_waitrequest); end
    total++; if (ram_we !== 1'b0 || ram_addr !== 8'h0) begin bad++; $display("FAIL reset_ram got=%b/%h exp=0/00", ram_we, ram_addr); end
  endtask

  task automatic test_jtag_read;
    logic [31:0] d; int n;
    load_mem; poke(8'h10, 32'hDEADBEEF);
    jtag_read(8'h10, d, n);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL jrd_data got=%h exp=deadbeef", d); end
    total++; if (n !== 3) begin bad++; $display("FAIL jrd_latency got=%0d exp=3", n); end
    jtag_write(32'h12345678, n);
    total++; if (n !== 2) begin bad++; $display("FAIL jwr_latency got=%0d exp=2", n); end
    total++; if (mem[8'h11] !== 32'h12345678) begin bad++; $display("FAIL jrd_autoinc got=%h exp=12345678", mem[8'h11]); end
  endtask

  task automatic test_jtag_write_wrap;
    logic [31:0] d; int n;
    logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
    pulse_a(8'hFE, 1'b0);
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL jaddr_load_ready got=%b exp=1", monitor_ready); end
    for (int i = 0; i < 3; i++) begin
      jtag_write(vals[i], n);
      total++; if (n !== 2) begin bad++; $display("FAIL wrap_wr_latency got=%0d exp=2", n); end
    end
    total++; if (mem[8'hFE] !== 32'hA || mem[8'hFF] !== 32'hB || mem[8'h00] !== 32'hC) begin
      bad++; $display("FAIL wrap_data got=%h,%h,%h exp=a,b,c", mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    jtag_read(8'h00, d, n);
    total++; if (d !== 32'hC) begin bad++; $display("FAIL wrap_readback got=%h exp=c", d); end
  endtask

  task automatic test_arbitration;
    int jd, cd, n; logic [31:0] jv, cv;
    do_reset;
    contend(8'h20, 8'h30, jd, cd, jv, cv);
    total++; if (jd !== 3 || cd !== 5) begin bad++; $display("FAIL arb_first_jtag got=j%0d/c%0d exp=j3/c5", jd, cd); end
    total++; if (jv !== ref_mem[8'h20] || cv !== ref_mem[8'h30]) begin
      bad++; $display("FAIL arb_first_data got=%h/%h exp=%h/%h", jv, cv, ref_mem[8'h20], ref_mem[8'h30]);
    end
    jtag_write(32'h0F0F0F0F, n);
    contend(8'h40, 8'h50, jd, cd, jv, cv);
    total++; if (jd !== 6 || cd !== 2) begin bad++; $display("FAIL arb_then_cpu got=j%0d/c%0d exp=j6/c2", jd, cd); end
    total++; if (jv !== ref_mem[8'h40] || cv !== ref_mem[8'h50]) begin
      bad++; $display("FAIL arb_then_cpu_data got=%h/%h exp=%h/%h", jv, cv, ref_mem[8'h40], ref_mem[8'h50]);
    end
  endtask

  task automatic test_back_to_back;
    int n_ev = 0; int last_kind = -1; int n; logic change_addr = 1'b0;
    logic [7:0] ja = 8'($urandom);
    pulse_a(ja, 1'b1);
    avs_address = 8'($urandom); avs_read = 1'b1;
    for (int c = 0; c < 400 && n_ev < 10; c++) begin
      tick;
      take_a = 1'b0;
      if (change_addr) begin avs_address = 8'($urandom); change_addr = 1'b0; end
      if (monitor_ready) begin
        total++; if (last_kind == 0 || MonDReg !== ref_mem[ja]) begin
          bad++; $display("FAIL b2b_jtag prev=%0d got=%h exp=%h", last_kind, MonDReg, ref_mem[ja]);
        end
        last_kind = 0; n_ev++;
        ja = 8'($urandom); jdo = '0; jdo[26 +: 8] = ja; jdo[35] = 1'b1; take_a = 1'b1;
      end
      if (!avs_waitrequest) begin
        total++; if (last_kind == 1 || avs_readdata !== ref_mem[avs_address]) begin
          bad++; $display("FAIL b2b_cpu prev=%0d got=%h exp=%h", last_kind, avs_readdata, ref_mem[avs_address]);
        end
        last_kind = 1; n_ev++; change_addr = 1'b1;
      end
    end
    total++; if (n_ev < 10) begin bad++; $display("FAIL b2b_progress got=%0d exp=10", n_ev); end
    avs_read = 1'b0; tick; take_a = 1'b0; wait_ready(n); tick; tick;
    m_jaddr = ja + 8'd1;
  endtask

  task automatic test_overrun;
    int n;
    pulse_a(8'h60, 1'b1); pulse_b(32'hCAFE0001);
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", monitor_error); end
    wait_ready(n);
    total++; if (MonDReg !== ref_mem[8'h60]) begin bad++; $display("FAIL ovr_rd_data got=%h exp=%h", MonDReg, ref_mem[8'h60]); end
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", monitor_error); end
    take_na = 1'b1; tick; take_na = 1'b0;
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", monitor_error); end
    check_mem("ovr_ram_unchanged");
    jdo = '0; jdo[26 +: 8] = 8'h62; jdo[35] = 1'b1; take_a = 1'b1; take_b = 1'b1;
    tick; take_a = 1'b0; take_b = 1'b0;
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL a_and_b_error got=%b exp=1", monitor_error); end
    wait_ready(n);
    total++; if (n !== 3 || MonDReg !== ref_mem[8'h62]) begin
      bad++; $display("FAIL a_and_b_read got=%0d/%h exp=3/%h", n, MonDReg, ref_mem[8'h62]);
    end
    take_na = 1'b1; tick; take_na = 1'b0;
    pulse_a(8'h63, 1'b1);
    jdo = '0; take_b = 1'b1; take_na = 1'b1; tick; take_b = 1'b0; take_na = 1'b0;
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", monitor_error); end
    wait_ready(n); take_na = 1'b1; tick; take_na = 1'b0;
    m_jaddr = 8'h64;
    check_mem("ovr_ram_final");
  endtask

  task automatic test_cpu_rom;
    logic [31:0] r; int n; logic we;
    cpu_op(1'b1, 8'h05, 32'h55, r, n, we);
    total++; if (n !== 1 || we !== 1'b0) begin bad++; $display("FAIL rom_write got=%0d/%b exp=1/0", n, we); end
    total++; if (mem[8'h05] !== ref_mem[8'h05]) begin bad++; $display("FAIL rom_unchanged got=%h exp=%h", mem[8'h05], ref_mem[8'h05]); end
    cpu_op(1'b1, 8'h40, 32'h55, r, n, we);
    total++; if (n !== 1 || we !== 1'b1 || mem[8'h40] !== 32'h55) begin
      bad++; $display("FAIL ram_write got=%0d/%b/%h exp=1/1/55", n, we, mem[8'h40]);
    end
    cpu_op(1'b0, 8'h40, 32'h0, r, n, we);
    total++; if (n !== 2 || r !== 32'h55) begin bad++; $display("FAIL cpu_read got=%0d/%h exp=2/55", n, r); end
  endtask

  task automatic test_random_ops;
    logic [31:0] r, d, e; int n; logic we; logic [7:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); d = $urandom; e = ref_mem[a];
      case ($urandom_range(0, 3))
        0: begin
          cpu_op(1'b1, a, d, r, n, we);
          total++; if (n !== 1 || we !== (a >= 8'(ROM))) begin bad++; $display("FAIL rnd_cpu_wr a=%h got=%0d/%b", a, n, we); end
        end
        1: begin
          cpu_op(1'b0, a, 32'h0, r, n, we);
          total++; if (n !== 2 || r !== e) begin bad++; $display("FAIL rnd_cpu_rd a=%h got=%0d/%h exp=2/%h", a, n, r, e); end
        end
        2: begin
          jtag_write(d, n);
          total++; if (n !== 2) begin bad++; $display("FAIL rnd_jtag_wr got=%0d exp=2", n); end
        end
        default: begin
          jtag_read(a, r, n);
          total++; if (n !== 3 || r !== e) begin bad++; $display("FAIL rnd_jtag_rd a=%h got=%0d/%h exp=3/%h", a, n, r, e); end
        end
      endcase
    end
    check_mem("rnd_ram");
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; int n;
    poke(8'h70, 32'h13579BDF);
    jtag_read(8'h70, d, n);
    pulse_a(8'h71, 1'b1); tick; tick;
    reset_n = 1'b0; tick;
    total++; if (monitor_ready !== 1'b0 || MonDReg !== 32'h0) begin
      bad++; $display("FAIL midrst_mon got=%b/%h exp=0/0", monitor_ready, MonDReg);
    end
    total++; if (avs_waitrequest !== 1'b1 || ram_we !== 1'b0) begin
      bad++; $display("FAIL midrst_bus got=%b/%b exp=1/0", avs_waitrequest, ram_we);
    end
    reset_n = 1'b1; m_jaddr = '0;
    tick; tick; tick;
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL midrst_no_retire got=%b exp=0", monitor_ready); end
    check_mem("midrst_ram");
    jtag_write(32'h0BADF00D, n);
    total++; if (n !== 2 || mem[8'h00] !== 32'h0BADF00D) begin
      bad++; $display("FAIL midrst_jaddr0 got=%0d/%h exp=2/0badf00d", n, mem[8'h00]);
    end
  endtask

  initial begin
    reset_n = 1'b0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0; jdo = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    init_mem = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0; seed = '0;
    test_reset;
    test_jtag_read;
    test_jtag_write_wrap;
    test_arbitration;
    test_back_to_back;
    test_overrun;
    test_cpu_rom;
    test_random_ops;
    test_reset_mid;
    check_mem("final_ram");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
